// File: rtl/typing_game_ctrl.sv
// Speed-typer game sequencer: filters PS/2 bytes into make codes, checks them against
// the parser's expected character, and tracks index, level, errors, score and countdown.
module typing_game_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_TIME_S  = 30,
  parameter int unsigned NUM_LEVELS    = 30,
  parameter int unsigned MAX_ERRORS    = 3,
  parameter int unsigned LOAD_SETTLE   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic [7:0]  comparison_data,
  input  logic [7:0]  num_char,
  output logic        parser_resetn,
  output logic        enable_next_level,
  output logic        get_next_character,
  output logic [7:0]  char_index,
  output logic [4:0]  level,
  output logic [3:0]  errors,
  output logic [15:0] score,
  output logic [7:0]  time_left,
  output logic        correct_pulse,
  output logic        wrong_pulse,
  output logic        game_over,
  output logic        game_won
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = $clog2(LOAD_SETTLE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_PLAY, S_ADVANCE, S_LEVEL_DONE, S_OVER, S_WON
  } state_e;

  state_e          state_q, state_d;
  logic            break_q, break_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [7:0]      char_index_q, char_index_d;
  logic [4:0]      level_q, level_d;
  logic [3:0]      errors_q, errors_d;
  logic [15:0]     score_q, score_d;
  logic [7:0]      time_left_q, time_left_d;
  logic            correct_q, correct_d;
  logic            wrong_q, wrong_d;

  logic            make_ok;
  logic            sec_wrap;
  logic            timeout;
  logic [3:0]      err_inc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      break_q      <= 1'b0;
      tick_q       <= '0;
      settle_q     <= '0;
      char_index_q <= '0;
      level_q      <= '0;
      errors_q     <= '0;
      score_q      <= '0;
      time_left_q  <= '0;
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      break_q      <= break_d;
      tick_q       <= tick_d;
      settle_q     <= settle_d;
      char_index_q <= char_index_d;
      level_q      <= level_d;
      errors_q     <= errors_d;
      score_q      <= score_d;
      time_left_q  <= time_left_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    break_d            = break_q;
    tick_d             = tick_q;
    settle_d           = settle_q;
    char_index_d       = char_index_q;
    level_d            = level_q;
    errors_d           = errors_q;
    score_d            = score_q;
    time_left_d        = time_left_q;
    correct_d          = 1'b0;
    wrong_d            = 1'b0;
    make_ok            = 1'b0;
    get_next_character = 1'b0;
    err_inc            = errors_q + 4'd1;
    sec_wrap           = (tick_q == TW'(TICKS_PER_SEC - 1));
    timeout            = sec_wrap && (time_left_q == 8'd1);

    // Break-code byte after F0 is swallowed; E0 prefixes are transparent.
    if (key_valid) begin
      if (break_q) begin
        break_d = 1'b0;
      end else if (key_code == 8'hF0) begin
        break_d = 1'b1;
      end else if (key_code != 8'hE0) begin
        make_ok = 1'b1;
      end
    end

    if (state_q == S_PLAY || state_q == S_ADVANCE) begin
      tick_d = sec_wrap ? '0 : tick_q + TW'(1);
      if (sec_wrap) time_left_d = time_left_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          level_d  = '0;
          errors_d = '0;
          score_d  = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        time_left_d  = 8'(ROUND_TIME_S);
        tick_d       = '0;
        char_index_d = '0;
        settle_d     = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(LOAD_SETTLE - 1)) begin
          state_d = (num_char == 8'd0) ? S_LEVEL_DONE : S_PLAY;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_PLAY: begin
        // Timeout wins over a simultaneous key, which is then dropped entirely.
        if (timeout) begin
          state_d = S_OVER;
        end else if (make_ok) begin
          if (key_code == comparison_data) begin
            correct_d    = 1'b1;
            score_d      = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            char_index_d = char_index_q + 8'd1;
            state_d      = S_ADVANCE;
          end else begin
            wrong_d  = 1'b1;
            errors_d = err_inc;
            if (err_inc == 4'(MAX_ERRORS)) state_d = S_OVER;
          end
        end
      end
      S_ADVANCE: begin
        if (timeout) begin
          state_d = S_OVER;
        end else if (char_index_q < num_char) begin
          get_next_character = 1'b1;
          state_d            = S_PLAY;
        end else begin
          state_d = S_LEVEL_DONE;
        end
      end
      S_LEVEL_DONE: begin
        if (level_q == 5'(NUM_LEVELS - 1)) begin
          state_d = S_WON;
        end else begin
          level_d = level_q + 5'd1;
          state_d = S_LOAD;
        end
      end
      S_OVER, S_WON: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign parser_resetn     = (state_q != S_IDLE);
  assign enable_next_level = (state_q == S_LOAD);
  assign game_over         = (state_q == S_OVER);
  assign game_won          = (state_q == S_WON);
  assign char_index        = char_index_q;
  assign level             = level_q;
  assign errors            = errors_q;
  assign score             = score_q;
  assign time_left         = time_left_q;
  assign correct_pulse     = correct_q;
  assign wrong_pulse       = wrong_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Directed bench for typing_game_ctrl: a main instance for game flow and a fast-timer
// instance for the countdown timeout.
module tb_typing_game_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, key_valid;
  logic [7:0]  key_code;
  logic [7:0]  comparison_data;
  logic        parser_resetn, enable_next_level, get_next_character;
  logic [7:0]  char_index;
  logic [4:0]  level;
  logic [3:0]  errors;
  logic [15:0] score;
  logic [7:0]  time_left;
  logic        correct_pulse, wrong_pulse, game_over, game_won;

  logic        t_start, t_key_valid;
  logic [7:0]  t_key_code;
  logic        t_parser_resetn, t_enable, t_get;
  logic [7:0]  t_char_index;
  logic [4:0]  t_level;
  logic [3:0]  t_errors;
  logic [15:0] t_score;
  logic [7:0]  t_time_left;
  logic        t_correct, t_wrong, t_over, t_won;

  int checks = 0;
  int failures = 0;
  int n_en = 0, n_get = 0, n_cor = 0, n_both = 0;
  int en0, g0, c0;
  logic [1:0] ptr;

  always #5 clk = ~clk;

  typing_game_ctrl #(
    .TICKS_PER_SEC(20), .ROUND_TIME_S(10), .NUM_LEVELS(2), .MAX_ERRORS(3), .LOAD_SETTLE(4)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid), .key_code(key_code),
    .comparison_data(comparison_data), .num_char(8'd3),
    .parser_resetn(parser_resetn), .enable_next_level(enable_next_level),
    .get_next_character(get_next_character), .char_index(char_index), .level(level),
    .errors(errors), .score(score), .time_left(time_left), .correct_pulse(correct_pulse),
    .wrong_pulse(wrong_pulse), .game_over(game_over), .game_won(game_won)
  );

  typing_game_ctrl #(
    .TICKS_PER_SEC(10), .ROUND_TIME_S(2), .NUM_LEVELS(2), .MAX_ERRORS(3), .LOAD_SETTLE(4)
  ) dut_t (
    .clk(clk), .resetn(resetn), .start(t_start), .key_valid(t_key_valid), .key_code(t_key_code),
    .comparison_data(8'h24), .num_char(8'd3),
    .parser_resetn(t_parser_resetn), .enable_next_level(t_enable),
    .get_next_character(t_get), .char_index(t_char_index), .level(t_level),
    .errors(t_errors), .score(t_score), .time_left(t_time_left), .correct_pulse(t_correct),
    .wrong_pulse(t_wrong), .game_over(t_over), .game_won(t_won)
  );

  // Parser stand-in: every level is the word "ECF" = 24,21,2B.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) ptr <= 2'd0;
    else if (enable_next_level) ptr <= 2'd0;
    else if (get_next_character) ptr <= ptr + 2'd1;
  end

  always_comb begin
    comparison_data = 8'h24;
    case (ptr)
      2'd1: comparison_data = 8'h21;
      2'd2: comparison_data = 8'h2B;
      default: comparison_data = 8'h24;
    endcase
  end

  always @(posedge clk) begin
    if (enable_next_level) n_en <= n_en + 1;
    if (get_next_character) n_get <= n_get + 1;
    if (correct_pulse) n_cor <= n_cor + 1;
    if (enable_next_level && get_next_character) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  // From PLAY at char 0: types the whole word, leaving the DUT in ADVANCE after the last key.
  task automatic type_word();
    send(8'h24); tick();
    send(8'h21); tick();
    send(8'h2B);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    t_start = 1'b0; t_key_valid = 1'b0; t_key_code = 8'h00;
    repeat (2) tick();
    chk("rst_parser_resetn", parser_resetn, 0);
    chk("rst_enable", enable_next_level, 0);
    chk("rst_level", level, 0);
    chk("rst_score", score, 0);
    chk("rst_time_left", time_left, 0);
    chk("rst_game_over", game_over, 0);
    resetn = 1'b1;
    tick();

    // Countdown timeout on the fast-timer instance.
    t_start = 1'b1; tick(); t_start = 1'b0;
    repeat (5) tick();
    repeat (9) tick();
    chk("t5_time_before_wrap", t_time_left, 2);
    tick();
    chk("t5_time_after_10", t_time_left, 1);
    repeat (9) tick();
    chk("t5_not_over_yet", t_over, 0);
    t_key_valid = 1'b1; t_key_code = 8'h24;
    tick();
    t_key_valid = 1'b0;
    chk("t5_over_after_20", t_over, 1);
    chk("t5_key_dropped_score", t_score, 0);
    chk("t5_key_dropped_pulse", t_correct, 0);
    chk("t5_time_zero", t_time_left, 0);

    // Word "ECF" completes level 0.
    en0 = n_en; g0 = n_get; c0 = n_cor;
    pulse_start();
    chk("t2_enable_in_load", enable_next_level, 1);
    chk("t2_parser_resetn", parser_resetn, 1);
    repeat (5) tick();
    chk("t2_one_enable", n_en - en0, 1);
    chk("t2_time_loaded", time_left, 10);
    send(8'h24);
    chk("t2_correct1", correct_pulse, 1);
    chk("t2_get1", get_next_character, 1);
    chk("t2_char1", char_index, 1);
    tick();
    chk("t2_get1_single", get_next_character, 0);
    send(8'h21);
    chk("t2_get2", get_next_character, 1);
    chk("t2_char2", char_index, 2);
    tick();
    send(8'h2B);
    chk("t2_correct3", correct_pulse, 1);
    chk("t2_no_get_last", get_next_character, 0);
    chk("t2_score3", score, 3);
    tick();
    tick();
    chk("t2_level1", level, 1);
    chk("t2_enable2", enable_next_level, 1);
    tick();
    chk("t2_char_reset", char_index, 0);
    chk("t2_gets", n_get - g0, 2);
    chk("t2_enables", n_en - en0, 2);
    chk("t2_corrects", n_cor - c0, 3);
    repeat (4) tick();

    // Byte filter, then wrong keys up to MAX_ERRORS.
    c0 = n_cor; g0 = n_get;
    send(8'hF0); send(8'h24); send(8'hE0);
    tick();
    chk("t3_no_correct", n_cor - c0, 0);
    chk("t3_char0", char_index, 0);
    chk("t3_errors0", errors, 0);
    send(8'h1C);
    chk("t4_wrong_pulse", wrong_pulse, 1);
    chk("t4_errors1", errors, 1);
    tick();
    send(8'h1C);
    tick();
    chk("t4_errors2", errors, 2);
    chk("t4_no_get", n_get - g0, 0);
    chk("t4_not_over", game_over, 0);
    send(8'h24);
    chk("t3_correct_after_filter", correct_pulse, 1);
    chk("t3_score4", score, 4);
    tick();
    send(8'h1C);
    chk("t4_errors3", errors, 3);
    chk("t4_game_over", game_over, 1);
    send(8'h21);
    chk("t4_frozen_score", score, 4);
    chk("t4_frozen_errors", errors, 3);
    chk("t4_no_pulse_over", correct_pulse, 0);
    tick();

    // Full two-level win.
    pulse_start();
    chk("t6_over_cleared", game_over, 0);
    chk("t6_idle_parser_reset", parser_resetn, 0);
    en0 = n_en;
    pulse_start();
    chk("t6_score_cleared", score, 0);
    chk("t6_errors_cleared", errors, 0);
    chk("t6_level_cleared", level, 0);
    repeat (5) tick();
    type_word();
    tick(); tick();
    repeat (5) tick();
    type_word();
    tick(); tick();
    chk("t6_game_won", game_won, 1);
    chk("t6_level_held", level, 1);
    chk("t6_score6", score, 6);
    repeat (3) tick();
    chk("t6_two_enables", n_en - en0, 2);
    chk("t6_won_held", game_won, 1);
    pulse_start();
    chk("t6_won_cleared", game_won, 0);
    chk("t6_parser_reset", parser_resetn, 0);

    // Asynchronous reset in the middle of level 1.
    pulse_start();
    repeat (5) tick();
    type_word();
    tick(); tick();
    repeat (5) tick();
    send(8'h24); tick();
    send(8'h21); tick();
    chk("t1_pre_level", level, 1);
    chk("t1_pre_score", score, 5);
    #3;
    resetn = 1'b0;
    #1;
    chk("t1_async_parser_resetn", parser_resetn, 0);
    chk("t1_async_level", level, 0);
    chk("t1_async_score", score, 0);
    chk("t1_async_char", char_index, 0);
    chk("t1_async_time", time_left, 0);
    chk("t1_async_enable", enable_next_level, 0);
    #2;
    resetn = 1'b1;
    tick();
    en0 = n_en;
    pulse_start();
    repeat (6) tick();
    chk("t1_one_enable", n_en - en0, 1);
    chk("strobes_never_together", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
